// File: rtl/mips_pkg.sv
// Shared MIPS integer-datapath constants and types used by the register file.
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/decoder5to32.sv
// Destination decoder for the register file: one-hot write enables with $zero never selected.
module decoder5to32 #(
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [2**ADDR_W-1:0] we
);
   always_comb begin
      we       = '0;
      if (en) we[addr] = 1'b1;
      we[0]    = 1'b0;
   end
endmodule

// File: rtl/regfile_write_bank.sv
// Write side and storage of the MIPS register file; r0 is a hard-wired zero.
// Optional same-cycle write-through is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_write_bank #(
   parameter int                        DATA_W  = mips_pkg::DATA_W,
   parameter int                        ADDR_W  = mips_pkg::ADDR_W,
   parameter logic [DATA_W-1:0]         RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic [(2**ADDR_W)*DATA_W-1:0] rf_flat,
   output logic                         wr_done,
   output logic [ADDR_W-1:0]            last_addr,
   output logic [15:0]                  wr_count
);
   import mips_pkg::*;

   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0]   we;
   logic              commit;
   logic              wr_done_d, wr_done_q;
   logic [ADDR_W-1:0] last_addr_d, last_addr_q;
   logic [15:0]       wr_count_d, wr_count_q;

   decoder5to32 #(.ADDR_W(ADDR_W)) u_dec (
      .en   (wr_en),
      .addr (wr_addr),
      .we   (we)
   );

   assign rf_flat[DATA_W-1:0] = '0;

   for (genvar n = 1; n < NREG; n++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)        r_q <= RST_VAL;
         else if (we[n]) r_q <= wr_data;
      end

`ifdef REGFILE_WR_BYPASS_EN
      // Write-first-half / read-second-half: the pending value is visible before the edge.
      assign rf_flat[DATA_W*n +: DATA_W] = we[n] ? wr_data : r_q;
`else
      assign rf_flat[DATA_W*n +: DATA_W] = r_q;
`endif
   end

   assign commit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

   always_comb begin
      wr_done_d   = commit;
      last_addr_d = commit ? wr_addr : last_addr_q;
      wr_count_d  = commit ? wr_count_q + 16'd1 : wr_count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_done_q   <= 1'b0;
         last_addr_q <= '0;
         wr_count_q  <= '0;
      end else begin
         wr_done_q   <= wr_done_d;
         last_addr_q <= last_addr_d;
         wr_count_q  <= wr_count_d;
      end
   end

   assign wr_done   = wr_done_q;
   assign last_addr = last_addr_q;
   assign wr_count  = wr_count_q;

   // An undriven destination during a write would silently corrupt an arbitrary register.
   a_addr_known: assert property (@(posedge clk) disable iff (rst) wr_en |-> !$isunknown(wr_addr))
      else $error("regfile_write_bank: X/Z on wr_addr while wr_en=1");
endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank (both with and without REGFILE_WR_BYPASS_EN).
module tb_regfile_write_bank;
   import mips_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [4:0]    wr_addr = 5'd0;
   word_t         wr_data = '0;
   logic [1023:0] rf_flat;
   logic          wr_done;
   logic [4:0]    last_addr;
   logic [15:0]   wr_count;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_write_bank dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rf_flat   (rf_flat),
      .wr_done   (wr_done),
      .last_addr (last_addr),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   function automatic word_t slice(input int n);
      return rf_flat[32*n +: 32];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [4:0] a, input word_t d);
      @(negedge clk);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
   endtask

   initial begin
      word_t exp_v;

      // Reset and release
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) check($sformatf("rst_slice%0d", i), slice(i), 32'h0);
      check("rst_wr_done", {31'b0, wr_done}, 32'h0);
      check("rst_wr_count", {16'b0, wr_count}, 32'h0);
      check("rst_last_addr", {27'b0, last_addr}, 32'h0);

      // Single write r5, then idle
      drive(1'b1, 5'd5, 32'hDEADBEEF);
      drive(1'b0, 5'd0, 32'h0);
      check("r5_value", slice(5), 32'hDEADBEEF);
      check("r5_wr_done", {31'b0, wr_done}, 32'h1);
      check("r5_last_addr", {27'b0, last_addr}, 32'd5);
      check("r5_wr_count", {16'b0, wr_count}, 32'd1);
      for (int i = 0; i < 32; i++)
         if (i != 5) check($sformatf("r5_other%0d", i), slice(i), 32'h0);
      @(negedge clk);
      check("r5_done_pulse_end", {31'b0, wr_done}, 32'h0);
      check("r5_hold", slice(5), 32'hDEADBEEF);

      // Write to $zero is discarded
      drive(1'b1, 5'd0, 32'hFFFFFFFF);
      #1 check("r0_comb", slice(0), 32'h0);
      drive(1'b0, 5'd0, 32'h0);
      check("r0_value", slice(0), 32'h0);
      check("r0_wr_done", {31'b0, wr_done}, 32'h0);
      check("r0_wr_count", {16'b0, wr_count}, 32'd1);
      check("r0_last_addr", {27'b0, last_addr}, 32'd5);

      // Back-to-back r31 = 1 then 2
      drive(1'b1, 5'd31, 32'd1);
      drive(1'b1, 5'd31, 32'd2);
`ifdef REGFILE_WR_BYPASS_EN
      exp_v = 32'd2;
`else
      exp_v = 32'd1;
`endif
      check("r31_first", slice(31), exp_v);
      drive(1'b0, 5'd0, 32'h0);
      check("r31_second", slice(31), 32'd2);
      check("r31_wr_count", {16'b0, wr_count}, 32'd3);

      // Same-cycle visibility of a pending write
      drive(1'b1, 5'd7, 32'h1234);
      #1;
`ifdef REGFILE_WR_BYPASS_EN
      exp_v = 32'h1234;
`else
      exp_v = 32'h0;
`endif
      check("r7_pre_edge", slice(7), exp_v);
      check("r7_pre_edge_r0", slice(0), 32'h0);
      drive(1'b0, 5'd0, 32'h0);
      check("r7_post_edge", slice(7), 32'h1234);
      check("r7_wr_count", {16'b0, wr_count}, 32'd4);

      // Per-slice address walk
      for (int n = 1; n < 32; n++) drive(1'b1, n[4:0], n * 32'h01010101);
      drive(1'b0, 5'd0, 32'h0);
      check("walk_r0", slice(0), 32'h0);
      for (int n = 1; n < 32; n++) check($sformatf("walk_r%0d", n), slice(n), n * 32'h01010101);
      check("walk_wr_count", {16'b0, wr_count}, 32'd35);
      check("walk_last_addr", {27'b0, last_addr}, 32'd31);

      // Asynchronous reset mid-cycle clears immediately
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) check($sformatf("arst_slice%0d", i), slice(i), 32'h0);
      check("arst_wr_done", {31'b0, wr_done}, 32'h0);
      check("arst_wr_count", {16'b0, wr_count}, 32'h0);
      check("arst_last_addr", {27'b0, last_addr}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Write whose edge coincides with reset is lost
      drive(1'b1, 5'd9, 32'hAAAA5555);
      #4 rst = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      rst   = 1'b0;
      #1;
      check("rstwr_r9", slice(9), 32'h0);
      check("rstwr_wr_count", {16'b0, wr_count}, 32'h0);
      check("rstwr_wr_done", {31'b0, wr_done}, 32'h0);

      // wr_count wrap after 65536 commits
      drive(1'b1, 5'd1, 32'h5A5A5A5A);
      repeat (65535) @(negedge clk);
      check("wrap_ffff", {16'b0, wr_count}, 32'h0000FFFF);
      @(negedge clk);
      wr_en = 1'b0;
      check("wrap_zero", {16'b0, wr_count}, 32'h0);
      check("wrap_r1", slice(1), 32'h5A5A5A5A);
      check("wrap_last_addr", {27'b0, last_addr}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
